// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath and its controlling state machine:
// bus source codes, ALU opcodes, C_bus load-enable bit positions and data width.
package datapath_pkg;

  localparam int DW = 16;
  localparam int CW = 10;

  typedef enum logic [3:0] {
    BUS_ZERO = 4'd0,
    BUS_PC   = 4'd1,
    BUS_DR   = 4'd2,
    BUS_TR   = 4'd3,
    BUS_R    = 4'd4,
    BUS_RA   = 4'd5,
    BUS_RB   = 4'd6,
    BUS_RC   = 4'd7,
    BUS_AC   = 4'd8,
    BUS_IR   = 4'd9,
    BUS_AR   = 4'd10
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_SHL  = 3'd6,
    ALU_CLR  = 3'd7
  } alu_op_e;

  localparam int C_AR   = 0;
  localparam int C_R    = 1;
  localparam int C_PC   = 2;
  localparam int C_DR   = 3;
  localparam int C_TR   = 4;
  localparam int C_RA   = 5;
  localparam int C_RB   = 6;
  localparam int C_RC   = 7;
  localparam int C_AC   = 8;
  localparam int C_OUTR = 9;

  // Wraps silently: 0xFFFF + 1 gives 0x0000.
  function automatic logic [DW-1:0] inc16(input logic [DW-1:0] v);
    return v + 16'd1;
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU operating on the accumulator and the shared bus.
// All results are truncated to 16 bits.
module alu
  import datapath_pkg::*;
(
  input  logic [DW-1:0] AC,
  input  logic [DW-1:0] bus,
  input  logic [2:0]    op,
  output logic [DW-1:0] result
);

  // Opcode decode; ALU_NONE passes AC through unchanged
  always_comb begin
    result = AC;
    case (op)
      ALU_NONE: result = AC;
      ALU_ADD:  result = AC + bus;
      ALU_SUB:  result = AC - bus;
      ALU_MUL:  result = AC * bus;
      ALU_AND:  result = AC & bus;
      ALU_OR:   result = AC | bus;
      ALU_SHL:  result = {AC[DW-2:0], 1'b0};
      ALU_CLR:  result = {DW{1'b0}};
      default:  result = AC;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Register file, shared bus and memory interface of the simple accumulator CPU.
// Control comes entirely from the external state_machine; all state is here.
module datapath
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    A_bus,
  input  logic [CW-1:0] C_bus,
  input  logic [2:0]    ALU,
  input  logic          LDIR,
  input  logic          PC_INC,
  input  logic          AC_INC,
  input  logic          RA_INC,
  input  logic          RB_INC,
  input  logic          RC_INC,
  input  logic          read,
  input  logic          write,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [5:0]    IR,
  output logic          Z_Flag,
  output logic [DW-1:0] out
);

  logic [DW-1:0] ar_q, ar_d, r_q, r_d, pc_q, pc_d, dr_q, dr_d, tr_q, tr_d;
  logic [DW-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d, ac_q, ac_d, outr_q, outr_d;
  logic [5:0]    ir_q, ir_d;
  logic          z_q, z_d;
  logic [DW-1:0] bus_s, alu_res_s;
  logic          ac_wr_s;

  // Bus source mux; unused codes read as zero
  always_comb begin
    bus_s = {DW{1'b0}};
    case (A_bus)
      BUS_ZERO: bus_s = {DW{1'b0}};
      BUS_PC:   bus_s = pc_q;
      BUS_DR:   bus_s = dr_q;
      BUS_TR:   bus_s = tr_q;
      BUS_R:    bus_s = r_q;
      BUS_RA:   bus_s = ra_q;
      BUS_RB:   bus_s = rb_q;
      BUS_RC:   bus_s = rc_q;
      BUS_AC:   bus_s = ac_q;
      BUS_IR:   bus_s = {10'd0, ir_q};
      BUS_AR:   bus_s = ar_q;
      default:  bus_s = {DW{1'b0}};
    endcase
  end

  alu u_alu (
    .AC     (ac_q),
    .bus    (bus_s),
    .op     (ALU),
    .result (alu_res_s)
  );

  // Next-state selection with per-register load/increment priority
  always_comb begin
    ar_d   = C_bus[C_AR]   ? bus_s : ar_q;
    r_d    = C_bus[C_R]    ? bus_s : r_q;
    tr_d   = C_bus[C_TR]   ? bus_s : tr_q;
    outr_d = C_bus[C_OUTR] ? bus_s : outr_q;

    if (C_bus[C_PC])      pc_d = bus_s;
    else if (PC_INC)      pc_d = inc16(pc_q);
    else                  pc_d = pc_q;

    if (C_bus[C_RA])      ra_d = bus_s;
    else if (RA_INC)      ra_d = inc16(ra_q);
    else                  ra_d = ra_q;

    if (C_bus[C_RB])      rb_d = bus_s;
    else if (RB_INC)      rb_d = inc16(rb_q);
    else                  rb_d = rb_q;

    if (C_bus[C_RC])      rc_d = bus_s;
    else if (RC_INC)      rc_d = inc16(rc_q);
    else                  rc_d = rc_q;

    // Memory read wins over a bus load into DR
    if (read)             dr_d = mem_rdata;
    else if (C_bus[C_DR]) dr_d = bus_s;
    else                  dr_d = dr_q;

    if (ALU != ALU_NONE)  ac_d = alu_res_s;
    else if (C_bus[C_AC]) ac_d = bus_s;
    else if (AC_INC)      ac_d = inc16(ac_q);
    else                  ac_d = ac_q;

    ac_wr_s = (ALU != ALU_NONE) | C_bus[C_AC] | AC_INC;

    if (ac_wr_s)          z_d = (ac_d == {DW{1'b0}});
    else                  z_d = z_q;

    if (LDIR)             ir_d = bus_s[5:0];
    else                  ir_d = ir_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_q   <= {DW{1'b0}};
      r_q    <= {DW{1'b0}};
      pc_q   <= {DW{1'b0}};
      dr_q   <= {DW{1'b0}};
      tr_q   <= {DW{1'b0}};
      ra_q   <= {DW{1'b0}};
      rb_q   <= {DW{1'b0}};
      rc_q   <= {DW{1'b0}};
      ac_q   <= {DW{1'b0}};
      outr_q <= {DW{1'b0}};
      ir_q   <= 6'd0;
      z_q    <= 1'b1;
    end else begin
      ar_q   <= ar_d;
      r_q    <= r_d;
      pc_q   <= pc_d;
      dr_q   <= dr_d;
      tr_q   <= tr_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      rc_q   <= rc_d;
      ac_q   <= ac_d;
      outr_q <= outr_d;
      ir_q   <= ir_d;
      z_q    <= z_d;
    end
  end

  assign mem_addr  = ar_q;
  assign mem_wdata = dr_q;
  assign mem_re    = read;
  assign mem_we    = write & ~read;
  assign IR        = ir_q;
  assign Z_Flag    = z_q;
  assign out       = outr_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: a register-array model tracks expected state and
// is compared against the DUT every cycle, plus literal checks on key results.
module tb_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  A_bus;
  logic [9:0]  C_bus;
  logic [2:0]  ALU;
  logic        LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC;
  logic        read, write;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr, mem_wdata, out;
  logic        mem_re, mem_we, Z_Flag;
  logic [5:0]  IR;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: index = C_bus bit (0 AR,1 R,2 PC,3 DR,4 TR,5 RA,6 RB,7 RC,8 AC,9 OUTR)
  logic [15:0] m_reg [10];
  logic [15:0] nxt   [10];
  logic [5:0]  m_ir;
  logic        m_z;
  logic [15:0] m_b;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .rst_n(rst_n), .A_bus(A_bus), .C_bus(C_bus), .ALU(ALU),
    .LDIR(LDIR), .PC_INC(PC_INC), .AC_INC(AC_INC), .RA_INC(RA_INC),
    .RB_INC(RB_INC), .RC_INC(RC_INC), .read(read), .write(write),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .IR(IR), .Z_Flag(Z_Flag), .out(out)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_bus(input logic [3:0] sel);
    case (sel)
      4'd1:    return m_reg[2];
      4'd2:    return m_reg[3];
      4'd3:    return m_reg[4];
      4'd4:    return m_reg[1];
      4'd5:    return m_reg[5];
      4'd6:    return m_reg[6];
      4'd7:    return m_reg[7];
      4'd8:    return m_reg[8];
      4'd9:    return {10'd0, m_ir};
      4'd10:   return m_reg[0];
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] m_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    case (op)
      3'd1:    full = {16'd0, a} + {16'd0, b};
      3'd2:    full = {16'd0, a} - {16'd0, b};
      3'd3:    full = {16'd0, a} * {16'd0, b};
      3'd4:    full = {16'd0, a & b};
      3'd5:    full = {16'd0, a | b};
      3'd6:    full = {16'd0, a} * 32'd2;
      3'd7:    full = 32'd0;
      default: full = {16'd0, a};
    endcase
    return full[15:0];
  endfunction

  // Model: apply effects lowest priority first so stronger writers overwrite
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) m_reg[i] = 16'd0;
      m_ir = 6'd0;
      m_z  = 1'b1;
    end else begin
      m_b = m_bus(A_bus);
      nxt = m_reg;
      if (PC_INC) nxt[2] = m_reg[2] + 16'd1;
      if (RA_INC) nxt[5] = m_reg[5] + 16'd1;
      if (RB_INC) nxt[6] = m_reg[6] + 16'd1;
      if (RC_INC) nxt[7] = m_reg[7] + 16'd1;
      if (AC_INC) nxt[8] = m_reg[8] + 16'd1;
      for (int i = 0; i < 10; i++) if (C_bus[i]) nxt[i] = m_b;
      if (read) nxt[3] = mem_rdata;
      if (ALU != 3'd0) nxt[8] = m_alu(ALU, m_reg[8], m_b);
      if (ALU != 3'd0 || C_bus[8] || AC_INC) m_z = (nxt[8] == 16'd0);
      if (LDIR) m_ir = m_b[5:0];
      m_reg = nxt;
    end
  end

  // Per-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out",   out,       m_reg[9]);
      check("cyc_ir",    {10'd0, IR}, {10'd0, m_ir});
      check("cyc_z",     {15'd0, Z_Flag}, {15'd0, m_z});
      check("cyc_addr",  mem_addr,  m_reg[0]);
      check("cyc_wdata", mem_wdata, m_reg[3]);
      check("cyc_re",    {15'd0, mem_re}, {15'd0, read});
      check("cyc_we",    {15'd0, mem_we}, {15'd0, write & ~read});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    A_bus = 4'd0; C_bus = 10'd0; ALU = 3'd0; LDIR = 1'b0;
    PC_INC = 1'b0; AC_INC = 1'b0; RA_INC = 1'b0; RB_INC = 1'b0; RC_INC = 1'b0;
    read = 1'b0; write = 1'b0; mem_rdata = 16'd0;
  endtask

  task automatic ld_dr(input logic [15:0] v);
    idle(); mem_rdata = v; read = 1'b1; tick(); idle();
  endtask

  task automatic show(input logic [3:0] sel);
    idle(); A_bus = sel; C_bus = 10'h200; tick(); idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("rst_out", out, 16'h0000);
    check("rst_ir", {10'd0, IR}, 16'h0000);
    check("rst_z", {15'd0, Z_Flag}, 16'h0001);
    check("rst_addr", mem_addr, 16'h0000);

    // Load, add
    ld_dr(16'h0005);
    check("dr_read", mem_wdata, 16'h0005);
    A_bus = 4'd2; C_bus = 10'h100; tick(); idle();
    check("ac_load_z", {15'd0, Z_Flag}, 16'h0000);
    ALU = 3'd1; A_bus = 4'd2; tick();
    show(4'd8);
    check("add_out", out, 16'h000A);
    check("model_ac", m_reg[8], 16'h000A);

    // Subtract to zero, ALU beats AC_INC
    ALU = 3'd7; tick(); idle();
    check("clr_z", {15'd0, Z_Flag}, 16'h0001);
    AC_INC = 1'b1; tick(); tick(); tick(); idle();
    show(4'd8);
    check("inc3", out, 16'h0003);
    A_bus = 4'd8; ALU = 3'd2; tick(); idle();
    check("sub_z", {15'd0, Z_Flag}, 16'h0001);
    AC_INC = 1'b1; ALU = 3'd1; A_bus = 4'd0; tick();
    show(4'd8);
    check("alu_over_inc", out, 16'h0000);
    ld_dr(16'h0007);
    A_bus = 4'd2; C_bus = 10'h100; AC_INC = 1'b1; tick();
    show(4'd8);
    check("load_over_inc", out, 16'h0007);

    // PC wrap and load-over-increment
    ld_dr(16'hFFFF);
    A_bus = 4'd2; C_bus = 10'h004; tick(); idle();
    PC_INC = 1'b1; tick();
    show(4'd1);
    check("pc_wrap", out, 16'h0000);
    ld_dr(16'h1234);
    A_bus = 4'd2; C_bus = 10'h010; tick(); idle();
    PC_INC = 1'b1; C_bus = 10'h004; A_bus = 4'd3; tick();
    show(4'd1);
    check("pc_load", out, 16'h1234);

    // Simultaneous read/write
    ld_dr(16'h0010);
    A_bus = 4'd2; C_bus = 10'h001; tick(); idle();
    check("ar_addr", mem_addr, 16'h0010);
    read = 1'b1; write = 1'b1; mem_rdata = 16'hBEEF; #1;
    check("rw_re", {15'd0, mem_re}, 16'h0001);
    check("rw_we", {15'd0, mem_we}, 16'h0000);
    tick(); idle();
    check("rw_dr", mem_wdata, 16'hBEEF);
    write = 1'b1; #1;
    check("w_we", {15'd0, mem_we}, 16'h0001);
    idle();
    read = 1'b1; mem_rdata = 16'h00AA; C_bus = 10'h008; A_bus = 4'd8; tick(); idle();
    check("read_over_load", mem_wdata, 16'h00AA);

    // Multiply, shift, and, or
    ld_dr(16'hBEEF);
    A_bus = 4'd2; C_bus = 10'h100; tick();
    ld_dr(16'h0003);
    ALU = 3'd3; A_bus = 4'd2; tick();
    ALU = 3'd6; tick();
    show(4'd8);
    check("mul_shl", out, 16'h799A);
    ALU = 3'd4; A_bus = 4'd2; tick();
    show(4'd8);
    check("and", out, 16'h0002);
    ALU = 3'd5; A_bus = 4'd2; tick();
    show(4'd8);
    check("or", out, 16'h0003);

    // Secondary registers and remaining bus codes
    RA_INC = 1'b1; tick(); tick();
    show(4'd5);
    check("ra_inc", out, 16'h0002);
    A_bus = 4'd2; C_bus = 10'h040; RB_INC = 1'b1; tick();
    show(4'd6);
    check("rb_load", out, 16'h0003);
    RC_INC = 1'b1; tick();
    show(4'd7);
    check("rc_inc", out, 16'h0001);
    A_bus = 4'd2; C_bus = 10'h002; tick();
    show(4'd4);
    check("r_load", out, 16'h0003);
    show(4'd10);
    check("bus_ar", out, 16'h0010);
    show(4'd13);
    check("bus_unused", out, 16'h0000);

    // IR load, then reset overriding everything
    ld_dr(16'h0039);
    A_bus = 4'd2; LDIR = 1'b1; tick(); idle();
    check("ldir", {10'd0, IR}, 16'h0039);
    show(4'd9);
    check("bus_ir", out, 16'h0039);
    rst_n = 1'b0; C_bus = 10'h3FF; ALU = 3'd1; A_bus = 4'd2; read = 1'b1;
    mem_rdata = 16'h5555; PC_INC = 1'b1; AC_INC = 1'b1; LDIR = 1'b1;
    tick();
    idle();
    check("rst2_out", out, 16'h0000);
    check("rst2_ir", {10'd0, IR}, 16'h0000);
    check("rst2_z", {15'd0, Z_Flag}, 16'h0001);
    check("rst2_addr", mem_addr, 16'h0000);
    check("rst2_wdata", mem_wdata, 16'h0000);
    rst_n = 1'b1;
    tick(); tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL have ports: A_bus  in  4  bus source select from state_machine.
REQ-004 SHALL have ports: C_bus  in  10  one-hot-per-bit register load enables from state_machine.
REQ-005 SHALL have ports: ALU  in  3  ALU opcode from state_machine.
REQ-006 SHALL have ports: LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC  in  1 each  IR load and register increment strobes.
REQ-007 SHALL have ports: read, write  in  1 each  memory read/write strobes.
REQ-008 SHALL have ports: mem_rdata  in  16  memory read data.
REQ-009 SHALL have ports: mem_addr  out  16  memory address.
REQ-010 SHALL have ports: mem_wdata  out  16  memory write data.
REQ-011 SHALL have ports: mem_re, mem_we  out  1 each  memory read/write enables.
REQ-012 SHALL have ports: IR  out  6  opcode to state_machine.
REQ-013 SHALL have ports: Z_Flag  out  1  AC-zero flag to state_machine.
REQ-014 SHALL have ports: out  out  16  output register OUTR.

Function
REQ-015 SHALL hold 16-bit registers AR, R, PC, DR, TR, RA, RB, RC, AC, OUTR and 6-bit register IR.
REQ-016 C_bus bit map SHALL be: 0 AR, 1 R, 2 PC, 3 DR, 4 TR, 5 RA, 6 RB, 7 RC, 8 AC, 9 OUTR; every set bit loads the bus value in the same cycle.
REQ-017 Bus SHALL be combinational from A_bus: 0 zero, 1 PC, 2 DR, 3 TR, 4 R, 5 RA, 6 RB, 7 RC, 8 AC, 9 {10'b0, IR}, 10 AR; codes 11-15 SHALL drive zero.
REQ-018 ALU SHALL be: 000 none, 001 AC+bus, 010 AC-bus, 011 low 16 bits of AC*bus, 100 AC&bus, 101 AC|bus, 110 AC<<1, 111 clear; a nonzero op SHALL write AC at the clock edge.
REQ-019 All arithmetic, including increments, SHALL be modulo 2^16 with no carry output; 0xFFFF+1 SHALL give 0x0000.
REQ-020 AC priority SHALL be: nonzero ALU > C_bus[8] > AC_INC.
REQ-021 PC, RA, RB, RC priority SHALL be: C_bus load > INC.
REQ-022 LDIR SHALL load IR <= bus[5:0] in the same cycle.
REQ-023 Z_Flag SHALL be registered and SHALL equal (new AC == 0) after every AC write; it SHALL hold its value otherwise.
REQ-024 mem_addr SHALL be AR, mem_wdata SHALL be DR, mem_re SHALL be read; all three combinational.
REQ-025 read SHALL load DR <= mem_rdata at the edge, with priority over C_bus[3].
REQ-026 mem_we SHALL be write & ~read; simultaneous read and write SHALL perform the read only.
REQ-027 Register write latency SHALL be 1 cycle; a value written is visible on the bus the following cycle.
REQ-028 With all control inputs 0, every register SHALL hold its value.

Reset
REQ-029 With rst_n=0 at a rising edge, all registers and IR SHALL become 0 and Z_Flag SHALL become 1; this SHALL override all control inputs, including mid-operation.
REQ-030 Outputs SHALL reflect reset values on the cycle after the reset edge; there SHALL be no asynchronous path.

Structure
REQ-031 A shared package SHALL hold the A_bus source codes, ALU opcodes, C_bus bit indices and data width (16), for use by both state_machine and datapath.
REQ-032 The ALU SHALL be a combinational sub-module named alu (inputs AC, bus, op; output result); all registers SHALL stay in datapath.

Verification
REQ-033 Reset, then ALU=000 and all controls 0 for 3 cycles -> all outputs 0, Z_Flag=1, IR=0.
REQ-034 mem_rdata=0x0005 with read=1; next cycle A_bus=2, C_bus[8]=1; next ALU=001 with A_bus=2 -> DR=5, AC=5, then AC=0x000A, Z_Flag=0.
REQ-035 AC=0x0003, A_bus=8 (AC), ALU=010 -> AC=0, Z_Flag=1; then AC_INC with ALU=001, A_bus=0 -> AC stays 0 (ALU wins).
REQ-036 PC=0xFFFF with PC_INC=1 -> PC=0x0000; PC_INC with C_bus[2]=1 and A_bus=3, TR=0x1234 -> PC=0x1234.
REQ-037 read=1 and write=1 with AR=0x0010 -> mem_re=1, mem_we=0, mem_addr=0x0010, DR <= mem_rdata.
REQ-038 DR=0x0039, A_bus=2, LDIR=1 -> IR=6'b111001; then rst_n=0 with C_bus=all ones -> all registers 0.
